// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock / reset controller.
//   state_t  : controller states
//   RETRY_W  : width of the failed-attempt counter
//   LOSS_W   : width of the optional lock-loss statistics counter
//   max3     : helper that sizes the shared cycle counter
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 16;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_reset_ctrl_sync2.sv
// sync2: two-flop synchroniser for one asynchronous bit, cleared to 0 by reset.
//   clk   in  sampling clock
//   reset in  synchronous, active-high
//   d     in  asynchronous input
//   q     out synchronised output (2-cycle latency)
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic d_p0;
  logic d_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      d_p0 <= 1'b0;
      d_p1 <= 1'b0;
    end else begin
      // stage 0: metastability capture
      d_p0 <= d;
      // stage 1: resolved output
      d_p1 <= d_p0;
    end
  end

  assign q = d_p1;

endmodule

// File: rtl/pll_lock_reset_ctrl.sv
// pll_lock_reset_ctrl: drives the rPLL reset, watches its lock output and holds
// the system reset until the PLL has been stably locked. Loss of lock restarts
// the PLL; repeated lock timeouts end in a sticky fail state.
// Optional feature: define PLL_LOCK_STATS_EN to add lock_loss_cnt.
// Ports:
//   clk           in   free-running reference clock (rPLL clkin)
//   reset         in   synchronous, active-high
//   pll_lock      in   rPLL lock, asynchronous to clk
//   pll_rst       out  rPLL reset, active-high
//   sys_rst       out  system reset, active-high
//   ready         out  high only while running
//   fail          out  sticky: lock not achieved within MAX_RETRIES attempts
//   retry_cnt     out  failed attempts in the current bring-up
//   lock_loss_cnt out  (PLL_LOCK_STATS_EN only) saturating count of lock losses in RUN
module pll_lock_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_lock,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOCK_STATS_EN
  ,
  output logic [LOSS_W-1:0]  lock_loss_cnt
`endif
);

  localparam int unsigned MAX_CNT = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock_s is the first of the consecutive
  // locked cycles, so STABLE itself only needs STABLE_CYCLES-1 of them.
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'((STABLE_CYCLES >= 2) ? (STABLE_CYCLES - 2) : 0);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic               lock_s;
  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry_nxt;

  sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        // Lock seen on the timeout cycle takes priority over the timeout.
        if (lock_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TO_LAST) begin
          retry_nxt = retry_cnt + RETRY_W'(1);
          state_nxt = (retry_nxt == RETRY_MAX) ? FAIL : PLL_RST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STB_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = PLL_RST;
          cnt_nxt   = '0;
        end
      end
      FAIL: begin
        state_nxt = FAIL;
      end
      default: begin
        state_nxt = PLL_RST;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge
  // as the state register; sys_rst and ready therefore never disagree.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PLL_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      pll_rst   <= (state_nxt == PLL_RST);
      sys_rst   <= (state_nxt != RUN);
      ready     <= (state_nxt == RUN);
      fail      <= (state_nxt == FAIL);
    end
  end

`ifdef PLL_LOCK_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_loss_cnt <= '0;
    end else if ((state == RUN) && (state_nxt == PLL_RST) && (lock_loss_cnt != '1)) begin
      lock_loss_cnt <= lock_loss_cnt + LOSS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Testbench for pll_lock_reset_ctrl. Expected event times are derived from the
// lock/reset timing rules: pll_lock reaches the controller after SYNC cycles and
// is acted on at the following edge; release needs STABLE_CYCLES consecutive
// synchronised-lock cycles; each reset attempt lasts RST_CYCLES and each lock
// wait LOCK_TIMEOUT cycles.
module tb_pll_lock_reset_ctrl;

  localparam int RST_CYCLES    = 16;
  localparam int LOCK_TIMEOUT  = 64;
  localparam int STABLE_CYCLES = 32;
  localparam int MAX_RETRIES   = 3;
  localparam int SYNC          = 2;

  localparam int S_PLL_RST = 0;
  localparam int S_SYS_RST = 1;
  localparam int S_READY   = 2;
  localparam int S_FAIL    = 3;
  localparam int S_RETRY   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
`ifdef PLL_LOCK_STATS_EN
  logic [15:0] lock_loss_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int disagree = 0;
  bit started = 1'b0;

  pll_lock_reset_ctrl #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pll_lock  (pll_lock),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt)
`ifdef PLL_LOCK_STATS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (started && (ready === sys_rst)) disagree <= disagree + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sig(input int sel);
    case (sel)
      S_PLL_RST: return {31'b0, pll_rst};
      S_SYS_RST: return {31'b0, sys_rst};
      S_READY:   return {31'b0, ready};
      S_FAIL:    return {31'b0, fail};
      S_RETRY:   return {28'b0, retry_cnt};
      default:   return '0;
    endcase
  endfunction

  // Returns the cycle at which sel first equals val, or -1 if the budget expires.
  task automatic wait_until(input int sel, input int val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sig(sel) === 32'(val)) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int r, w, l, d, at, k, wd, prev, bad, losses;
    reset    = 1'b1;
    pll_lock = 1'b0;
    losses   = 0;

    // Reset values and first bring-up with lock 10 cycles after pll_rst falls
    repeat (4) tick();
    started = 1'b1;
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst", sys_rst, 1);
    check("rst_ready", ready, 0);
    check("rst_fail", fail, 0);
    check("rst_retry", retry_cnt, 0);
`ifdef PLL_LOCK_STATS_EN
    check("rst_loss_cnt", lock_loss_cnt, 0);
`endif
    reset = 1'b0;
    r = cyc;
    wait_until(S_PLL_RST, 0, RST_CYCLES + 8, at);
    check("pll_rst_hold", at, r + RST_CYCLES);
    repeat (10) tick();
    pll_lock = 1'b1;
    l = cyc;
    wait_until(S_SYS_RST, 0, 200, at);
    check("release_time", at, l + SYNC + STABLE_CYCLES);
    check("release_ready", ready, 1);
    check("release_retry", retry_cnt, 0);

    // Loss of lock in RUN and re-lock, with random timing
    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(3, 20)) tick();
      pll_lock = 1'b0;
      d = cyc;
      wait_until(S_READY, 0, 10, at);
      check("loss_ready_fall", at, d + SYNC + 1);
      check("loss_sys_rst", sys_rst, 1);
      check("loss_pll_rst", pll_rst, 1);
      wait_until(S_PLL_RST, 0, RST_CYCLES + 8, at);
      check("loss_pll_rst_hold", at, d + SYNC + 1 + RST_CYCLES);
      repeat ($urandom_range(1, 50)) tick();
      pll_lock = 1'b1;
      l = cyc;
      wait_until(S_SYS_RST, 0, 200, at);
      check("relock_release", at, l + SYNC + STABLE_CYCLES);
      check("relock_retry", retry_cnt, 0);
      losses++;
`ifdef PLL_LOCK_STATS_EN
      check("loss_cnt", lock_loss_cnt, losses);
`endif
    end

    // Reset asserted while running
    repeat ($urandom_range(2, 10)) tick();
    reset = 1'b1;
    tick();
    check("midrst_pll_rst", pll_rst, 1);
    check("midrst_sys_rst", sys_rst, 1);
    check("midrst_ready", ready, 0);
    check("midrst_fail", fail, 0);
`ifdef PLL_LOCK_STATS_EN
    check("midrst_loss_cnt", lock_loss_cnt, 0);
`endif
    pll_lock = 1'b0;
    tick();
    reset = 1'b0;
    r = cyc;

    // Lock glitch while STABLE: release needs a fresh full stable window
    wait_until(S_PLL_RST, 0, RST_CYCLES + 8, at);
    check("glitch_pll_rst_hold", at, r + RST_CYCLES);
    repeat (5) tick();
    pll_lock = 1'b1;
    l = cyc;
    k = $urandom_range(3, 31);
    wd = $urandom_range(1, 3);
    repeat (k) tick();
    pll_lock = 1'b0;
    repeat (wd) tick();
    pll_lock = 1'b1;
    w = cyc;
    wait_until(S_SYS_RST, 0, 200, at);
    check("glitch_release", at, w + SYNC + STABLE_CYCLES);
    check("glitch_retry", retry_cnt, 0);

    // Lock first visible on the exact timeout cycle
    reset = 1'b1;
    pll_lock = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    r = cyc;
    wait_until(S_PLL_RST, 0, RST_CYCLES + 8, at);
    w = at;
    repeat (LOCK_TIMEOUT - SYNC - 1) tick();
    pll_lock = 1'b1;
    l = cyc;
    wait_until(S_SYS_RST, 0, 200, at);
    check("edge_timeout_release", at, l + SYNC + STABLE_CYCLES);
    check("edge_timeout_retry", retry_cnt, 0);

    // Lock one cycle too late: timeout is charged, then retry clears in RUN
    reset = 1'b1;
    pll_lock = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    wait_until(S_PLL_RST, 0, RST_CYCLES + 8, at);
    w = at;
    repeat (LOCK_TIMEOUT - SYNC) tick();
    pll_lock = 1'b1;
    wait_until(S_RETRY, 1, 20, at);
    check("late_lock_retry_time", at, w + LOCK_TIMEOUT);
    check("late_lock_pll_rst", pll_rst, 1);
    wait_until(S_READY, 1, 300, at);
    check("late_lock_ready", ready, 1);
    check("late_lock_retry_cleared", retry_cnt, 0);

    // Lock never asserts: three timeouts then sticky fail
    reset = 1'b1;
    pll_lock = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    r = cyc;
    prev = r + RST_CYCLES + LOCK_TIMEOUT;
    wait_until(S_RETRY, 1, 300, at);
    check("fail_retry1_time", at, prev);
    check("fail_retry1_pll_rst", pll_rst, 1);
    prev = prev + RST_CYCLES + LOCK_TIMEOUT;
    wait_until(S_RETRY, 2, 300, at);
    check("fail_retry2_time", at, prev);
    prev = prev + RST_CYCLES + LOCK_TIMEOUT;
    wait_until(S_RETRY, 3, 300, at);
    check("fail_retry3_time", at, prev);
    check("fail_flag", fail, 1);
    check("fail_pll_rst", pll_rst, 0);
    check("fail_sys_rst", sys_rst, 1);
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (i == 70) pll_lock = 1'b1;
      if (pll_rst !== 1'b0 || sys_rst !== 1'b1 || fail !== 1'b1 || ready !== 1'b0 ||
          retry_cnt !== 4'd3) bad++;
    end
    check("fail_sticky", bad, 0);
    reset = 1'b1;
    tick();
    check("fail_reset_fail", fail, 0);
    check("fail_reset_pll_rst", pll_rst, 1);
    check("fail_reset_retry", retry_cnt, 0);
    reset = 1'b0;
    tick();

    check("ready_sys_rst_agree", disagree, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
